// File: rtl/instr_fetch_sequencer.sv
// IF-stage controller: owns the PC, drives the combinational instruction memory and fills the IF/ID register.
// Latency: PC to IF/ID valid takes 1 cycle. Backpressure: the IF/ID entry holds while id_ready is low.
module instr_fetch_sequencer #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  localparam logic [63:0] IMEM_END = 64'(IMEM_BYTES);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic        redir_ok, redir_bad, advance, consumed;
  logic [63:0] pc_inc, pc_seq;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00) && (redirect_pc < IMEM_END);
  assign redir_bad = redirect_valid && !redir_ok;
  assign advance   = !if_valid_q || id_ready;
  assign consumed  = if_valid_q && id_ready;
  assign pc_inc    = pc_q + 64'd4;
  assign pc_seq    = (pc_inc == IMEM_END) ? 64'd0 : pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir_bad)     state_d = HALT;
        else if (redir_ok) state_d = RUN;
        else if (halt_req) state_d = HALT;
      end
      HALT: begin
        // A fault pins HALT until a legal redirect clears it.
        if (redir_ok) state_d = RUN;
        else if (!redir_bad && !halt_req && !fault_q) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    fault_d    = fault_q;
    count_d    = count_q;
    case (state_q)
      BOOT: begin
        if (redir_ok)  pc_d    = redirect_pc;
        if (redir_bad) fault_d = 1'b1;
      end
      RUN: begin
        if (redir_bad) begin
          fault_d    = 1'b1;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (redir_ok) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (halt_req) begin
          if (consumed) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end else if (advance) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          count_d    = count_q + 32'd1;
          pc_d       = pc_seq;
        end
      end
      HALT: begin
        if (consumed) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
        if (redir_ok) begin
          pc_d       = redirect_pc;
          fault_d    = 1'b0;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (redir_bad) begin
          fault_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= 64'd0;
      fault_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed vector table, async-reset sequence, randomized run against a reference model.
module tb_instr_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0 = 32'h02853483, W1 = 32'h009A84B3, W2 = 32'h00148493, W3 = 32'h02953423;
  localparam int IMEM = 16;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        halt_req = 1'b0;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [4];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 64'd16) ? mem[imem_addr[3:2]] : 32'hDEAD_BEEF;

  instr_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        halt;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_ifpc;
    logic        e_fault;
    logic [31:0] e_cnt;
    logic [63:0] e_addr;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t v(logic rv, logic [63:0] rpc, logic halt, logic rdy, logic ev,
                             logic [31:0] ei, logic [63:0] ep, logic ef, logic [31:0] ec,
                             logic [63:0] ea);
    vec_t r;
    r.rv = rv; r.rpc = rpc; r.halt = halt; r.rdy = rdy;
    r.e_valid = ev; r.e_instr = ei; r.e_ifpc = ep; r.e_fault = ef; r.e_cnt = ec; r.e_addr = ea;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ev, logic [31:0] ei, logic [63:0] ep, logic ef,
                         logic [31:0] ec, logic [63:0] ea);
    chk({tag, ".if_valid"},    64'(if_valid),    64'(ev));
    chk({tag, ".if_instr"},    64'(if_instr),    64'(ei));
    chk({tag, ".if_pc"},       if_pc,            ep);
    chk({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(ef));
    chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(ec));
    chk({tag, ".imem_addr"},   imem_addr,        ea);
  endtask

  // Reference model: state of the fetch unit after the next clock edge, from the behavioural rules.
  int          m_mode;
  logic [63:0] m_pc, m_ifpc;
  logic        m_valid, m_fault;
  logic [31:0] m_instr, m_cnt;

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 64'd0; m_ifpc = 64'd0; m_valid = 1'b0;
    m_fault = 1'b0; m_instr = NOP; m_cnt = 32'd0;
  endtask

  task automatic model_step(logic rv, logic [63:0] rpc, logic halt, logic rdy);
    logic legal, bad;
    legal = rv && (rpc % 4 == 0) && (rpc < 64'(IMEM));
    bad   = rv && !legal;
    if (m_mode == M_BOOT) begin
      if (legal) m_pc = rpc;
      if (bad) m_fault = 1'b1;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (bad) begin
        m_fault = 1'b1; m_valid = 1'b0; m_instr = NOP; m_mode = M_HALT;
      end else if (legal) begin
        m_pc = rpc; m_valid = 1'b0; m_instr = NOP;
      end else if (halt) begin
        m_mode = M_HALT;
        if (m_valid && rdy) begin m_valid = 1'b0; m_instr = NOP; end
      end else if (!m_valid || rdy) begin
        m_instr = mem[int'(m_pc / 4)]; m_ifpc = m_pc; m_valid = 1'b1;
        m_cnt = m_cnt + 1; m_pc = (m_pc + 4) % 64'(IMEM);
      end
    end else begin
      if (m_valid && rdy) begin m_valid = 1'b0; m_instr = NOP; end
      if (legal) begin
        m_pc = rpc; m_fault = 1'b0; m_valid = 1'b0; m_instr = NOP; m_mode = M_RUN;
      end else if (bad) begin
        m_fault = 1'b1;
      end else if (!halt && !m_fault) begin
        m_mode = M_RUN;
      end
    end
  endtask

  initial begin
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;

    tbl[0]  = v(0, 0,  0, 1, 0, NOP, 0,  0, 0,  0);
    tbl[1]  = v(0, 0,  0, 1, 1, W0,  0,  0, 1,  4);
    tbl[2]  = v(0, 0,  0, 1, 1, W1,  4,  0, 2,  8);
    tbl[3]  = v(0, 0,  0, 1, 1, W2,  8,  0, 3,  12);
    tbl[4]  = v(0, 0,  0, 1, 1, W3,  12, 0, 4,  0);
    tbl[5]  = v(0, 0,  0, 1, 1, W0,  0,  0, 5,  4);
    tbl[6]  = v(0, 0,  0, 1, 1, W1,  4,  0, 6,  8);
    tbl[7]  = v(0, 0,  0, 0, 1, W1,  4,  0, 6,  8);
    tbl[8]  = v(0, 0,  0, 0, 1, W1,  4,  0, 6,  8);
    tbl[9]  = v(0, 0,  0, 0, 1, W1,  4,  0, 6,  8);
    tbl[10] = v(0, 0,  0, 1, 1, W2,  8,  0, 7,  12);
    tbl[11] = v(0, 0,  0, 1, 1, W3,  12, 0, 8,  0);
    tbl[12] = v(0, 0,  0, 1, 1, W0,  0,  0, 9,  4);
    tbl[13] = v(0, 0,  0, 1, 1, W1,  4,  0, 10, 8);
    tbl[14] = v(1, 12, 0, 0, 0, NOP, 4,  0, 10, 12);
    tbl[15] = v(0, 0,  0, 0, 1, W3,  12, 0, 11, 0);
    tbl[16] = v(1, 6,  0, 1, 0, NOP, 12, 1, 11, 0);
    tbl[17] = v(0, 0,  0, 1, 0, NOP, 12, 1, 11, 0);
    tbl[18] = v(1, 0,  0, 1, 0, NOP, 12, 0, 11, 0);
    tbl[19] = v(0, 0,  0, 1, 1, W0,  0,  0, 12, 4);
    tbl[20] = v(1, 16, 0, 1, 0, NOP, 0,  1, 12, 4);
    tbl[21] = v(1, 0,  0, 1, 0, NOP, 0,  0, 12, 0);
    tbl[22] = v(0, 0,  0, 1, 1, W0,  0,  0, 13, 4);
    tbl[23] = v(0, 0,  1, 0, 1, W0,  0,  0, 13, 4);
    tbl[24] = v(0, 0,  1, 0, 1, W0,  0,  0, 13, 4);
    tbl[25] = v(0, 0,  1, 1, 0, NOP, 0,  0, 13, 4);
    tbl[26] = v(0, 0,  1, 1, 0, NOP, 0,  0, 13, 4);
    tbl[27] = v(0, 0,  0, 1, 0, NOP, 0,  0, 13, 4);
    tbl[28] = v(0, 0,  0, 1, 1, W1,  4,  0, 14, 8);
    tbl[29] = v(0, 0,  0, 1, 1, W2,  8,  0, 15, 12);
    tbl[30] = v(0, 0,  0, 0, 1, W2,  8,  0, 15, 12);

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    chk_all("reset", 0, NOP, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      halt_req       = tbl[i].halt;
      id_ready       = tbl[i].rdy;
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_ifpc,
              tbl[i].e_fault, tbl[i].e_cnt, tbl[i].e_addr);
    end

    // Asynchronous reset mid-stream while stalled: outputs clear before the next edge.
    redirect_valid = 1'b0; halt_req = 1'b0; id_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, NOP, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    chk_all("boot_bubble", 0, NOP, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("restart", 1, W0, 0, 0, 1, 4);

    // Randomized run against the reference model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [63:0] tgt;
      chk_all($sformatf("rand%0d", c), m_valid, m_instr, m_ifpc, m_fault, m_cnt, m_pc);
      case ($urandom_range(0, 5))
        0: tgt = 64'd0;
        1: tgt = 64'd4;
        2: tgt = 64'd8;
        3: tgt = 64'd12;
        4: tgt = 64'($urandom_range(0, 20));
        default: tgt = {$urandom, $urandom};
      endcase
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = tgt;
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      id_ready       = ($urandom_range(0, 3) != 0);
      model_step(redirect_valid, redirect_pc, halt_req, id_ready);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- IF-stage controller for the 5-stage RISC-V pipeline.
- Owns the program counter and drives the combinational instruction memory address every cycle.
- Captures the returned word into the IF/ID pipeline register and hands it to decode via a valid/ready handshake.
- Handles branch/jump redirects (flush), decode back-pressure (stall), halt/resume and illegal-target faults.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- IMEM_BYTES, 16, instruction memory size in bytes; multiple of 4; sequential PC wraps to 0 past the last word.
- NOP_INSTR, 32'h00000013, value driven on if_instr when no instruction is valid (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  64  instruction memory byte address; equals pc_q combinationally.
- imem_rdata  in  32  instruction word from memory, same-cycle combinational return.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  64  PC of if_instr.
- id_ready  in  1  decode accepts IF/ID this cycle.
- redirect_valid  in  1  EX-stage branch taken / jump; one-cycle pulse.
- redirect_pc  in  64  redirect target.
- halt_req  in  1  stop fetching (level).
- fetch_fault  out  1  sticky: illegal redirect target seen.
- fetch_count  out  32  number of instructions issued into IF/ID; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - pc_q=RESET_PC; if_valid=0; if_instr=NOP_INSTR; if_pc=0; fetch_fault=0; fetch_count=0; state=BOOT.
  - Reset mid-operation discards any held instruction immediately.
- States: BOOT, RUN, HALT.
- BOOT: no capture; next state RUN unconditionally (one bubble after reset release).
- RUN, priority order per cycle:
  - 1) redirect_valid with illegal target (redirect_pc[1:0]!=0 or redirect_pc>=IMEM_BYTES): fetch_fault<=1, if_valid<=0, if_instr<=NOP_INSTR, pc_q unchanged, state<=HALT.
  - 2) redirect_valid with legal target: pc_q<=redirect_pc, if_valid<=0, if_instr<=NOP_INSTR (flush, even if id_ready=0 and IF/ID held). The first instruction from the target appears in IF/ID 1 cycle later.
  - 3) halt_req: state<=HALT, no capture, pc_q unchanged; a held IF/ID entry remains until consumed.
  - 4) advance = !if_valid || id_ready. If advance: if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1, fetch_count<=fetch_count+1, pc_q<=(pc_q+4==IMEM_BYTES)?0:pc_q+4.
  - 5) Otherwise stall: all registers hold. imem_addr stays at pc_q.
- HALT:
  - No capture.
  - If if_valid && id_ready: if_valid<=0, if_instr<=NOP_INSTR.
  - A legal redirect_valid sets pc_q<=redirect_pc, clears fetch_fault, flushes IF/ID and sets state<=RUN, even if halt_req is still high (RUN re-enters HALT the next cycle).
  - An illegal redirect keeps HALT and sets fetch_fault.
  - Deassertion of halt_req alone returns to RUN only when fetch_fault=0.
- Throughput: one instruction per cycle while id_ready=1 and no redirect.
- Latency: pc_q to if_instr valid is 1 cycle.
- if_valid never drops without a handshake except on flush, fault or reset.
- redirect_valid in BOOT is latched into pc_q (legality checked as in RUN); state still goes to RUN.

Test Plan:
- Reset release, image words @0..12 = 0x02853483, 0x009A84B3, 0x00148493, 0x02953423, id_ready=1 -> BOOT bubble, then if_instr 0x02853483/0x009A84B3/0x00148493/0x02953423 with if_pc 0/4/8/12, then wrap to if_pc=0; fetch_count=5 after 5 captures.
- id_ready=0 for 3 cycles while if_pc=4 valid -> if_instr holds 0x009A84B3, pc_q holds 8, fetch_count unchanged; release -> next if_pc=8.
- redirect_valid, redirect_pc=12 while stalled at if_pc=4 -> next cycle if_valid=0, if_instr=NOP; following cycle if_pc=12, if_instr=0x02953423.
- redirect_pc=6 (misaligned) and, separately, redirect_pc=16 -> fetch_fault=1, state HALT, if_valid=0; a later legal redirect to 0 clears the fault and resumes at if_pc=0.
- halt_req=1 with valid entry and id_ready=0 -> entry held, no new capture; id_ready=1 -> if_valid=0; halt_req=0 -> fetch resumes from the held pc_q.
- Assert rst_n=0 mid-stream while stalled -> outputs return to reset values asynchronously (before the next clk edge); after release the sequence restarts at RESET_PC with a BOOT bubble.
